// File: rtl/fetch_sequencer_pkg.sv
// Shared core package: fetch FSM states, reset PC default and
// the opcode/branch constants used across the front end.
`timescale 1ns/1ps
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INSTR_W          = 32;

  // Major opcodes that change control flow
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Branch funct3 encodings
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH-entry synchronous FIFO of {pc, instr}.
// Clear has priority over push and pop; head entry is shown combinationally.
`timescale 1ns/1ps
module fetch_fifo
  import fetch_sequencer_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_push,
  input  logic               i_pop,
  input  logic [XLEN-1:0]    i_pc,
  input  logic [INSTR_W-1:0] i_instr,
  output logic [XLEN-1:0]    o_pc,
  output logic [INSTR_W-1:0] o_instr,
  output logic [CW-1:0]      o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][XLEN-1:0]    pc_mem;
  logic [DEPTH-1:0][INSTR_W-1:0] instr_mem;
  logic [PW-1:0]                 wr_ptr, rd_ptr;
  logic [CW-1:0]                 count;
  logic                          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Guard against underflow; a push into a full buffer is only legal alongside a pop
  always_comb begin
    do_pop  = i_pop & (count != '0);
    do_push = i_push & ((count != CW'(DEPTH)) | do_pop);
  end

  // Storage, pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_mem    <= '0;
      instr_mem <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else if (i_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        pc_mem[wr_ptr]    <= i_pc;
        instr_mem[wr_ptr] <= i_instr;
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign o_pc    = pc_mem[rd_ptr];
  assign o_instr = instr_mem[rd_ptr];
  assign o_count = count;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: sequential PC generation, req/gnt/rvalid
// handshake, response buffering and branch/trap redirects with flush.
// Optional feature: FETCH_MISALIGN_EXC_EN (misaligned branch target raises
// an exception and parks fetch in HALT instead of truncating the target).
`timescale 1ns/1ps
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = XLEN'(RESET_PC_DEFAULT),
  parameter int              MAX_OUTSTANDING = 2,
  parameter int              FIFO_DEPTH      = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_ex_valid,
  input  logic               i_branch_taken,
  input  logic [XLEN-1:0]    i_pc_branch,
  input  logic               i_redirect_valid,
  input  logic [XLEN-1:0]    i_redirect_pc,
  output logic               o_imem_req,
  output logic [XLEN-1:0]    o_imem_addr,
  input  logic               i_imem_gnt,
  input  logic               i_imem_rvalid,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  output logic               o_if_valid,
  output logic [XLEN-1:0]    o_if_pc,
  output logic [INSTR_W-1:0] o_if_instr,
  input  logic               i_if_ready,
`ifdef FETCH_MISALIGN_EXC_EN
  output logic               o_exc_misaligned,
  output logic [XLEN-1:0]    o_exc_addr,
`endif
  output logic               o_flush
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = 2;  // MAX_OUTSTANDING is at most 3

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, resp_pc_q;
  logic [OW-1:0]   outst_q, outst_d, discard_q;
  logic [CW-1:0]   fifo_count;
  logic [XLEN-1:0] br_target, target;
  logic            br_hit, ext_hit, misalign, redirect;
  logic            accept, push, pop;

  // Redirect arbitration: trap/CSR wins over the branch unit
  always_comb begin
    br_hit   = i_ex_valid & i_branch_taken & (state_q != HALT);
    ext_hit  = i_redirect_valid;
    misalign = 1'b0;
`ifdef FETCH_MISALIGN_EXC_EN
    br_target = i_pc_branch;
    misalign  = br_hit & ~ext_hit & (i_pc_branch[1:0] != 2'b00);
`else
    br_target = i_pc_branch & ~XLEN'(3);
`endif
    redirect = ext_hit | (br_hit & ~misalign);
    target   = ext_hit ? i_redirect_pc : br_target;
    o_flush  = redirect | misalign;
  end

  // Request throttle keeps every in-flight word guaranteed a buffer slot
  always_comb begin
    o_imem_req = (state_q == RUN) &&
                 (int'(outst_q) < MAX_OUTSTANDING) &&
                 (int'(fifo_count) + int'(outst_q) < FIFO_DEPTH);
    accept     = o_imem_req & i_imem_gnt;
    push       = i_imem_rvalid & (discard_q == '0);
    pop        = o_if_valid & i_if_ready;
    outst_d    = outst_q + OW'(accept) - OW'(i_imem_rvalid);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (misalign) state_d = HALT;
      HALT:    if (ext_hit) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= BOOT;
    else          state_q <= state_d;
  end

  // PCs and handshake counters; a flush marks every in-flight word as stale
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      outst_q <= outst_d;
      if (o_flush)                              discard_q <= outst_d;
      else if (i_imem_rvalid && discard_q != 0) discard_q <= discard_q - 1'b1;
      if (redirect)    fetch_pc_q <= target;
      else if (accept) fetch_pc_q <= fetch_pc_q + XLEN'(4);
      if (redirect)    resp_pc_q  <= target;
      else if (push)   resp_pc_q  <= resp_pc_q + XLEN'(4);
    end
  end

`ifdef FETCH_MISALIGN_EXC_EN
  // One-cycle exception pulse with the offending target held for inspection
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_exc_misaligned <= 1'b0;
      o_exc_addr       <= '0;
    end else begin
      o_exc_misaligned <= misalign;
      if (misalign) o_exc_addr <= i_pc_branch;
    end
  end
`endif

  assign o_imem_addr = fetch_pc_q;
  assign o_if_valid  = (fifo_count != '0);

  fetch_fifo #(.XLEN(XLEN), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (o_flush),
    .i_push  (push),
    .i_pop   (pop),
    .i_pc    (resp_pc_q),
    .i_instr (i_imem_rdata),
    .o_pc    (o_if_pc),
    .o_instr (o_if_instr),
    .o_count (fifo_count)
  );

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller sitting between the instruction memory port and the IF/ID stage. Generates the sequential fetch PC, issues requests over a req/gnt/rvalid handshake, buffers returned words with their PCs, and applies PC redirects from the branch unit (EX stage) and from the trap/CSR path. On each redirect it flushes the younger pipeline stages and discards in-flight responses from the old path.

## Interface
Parameters:
- `XLEN`, 32, address/PC width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `MAX_OUTSTANDING`, 2, maximum granted-but-unanswered requests (1..3)
- `FIFO_DEPTH`, 2, instruction buffer entries; must satisfy ≥ `MAX_OUTSTANDING`

Ports:
- `i_clk` in 1 — clock
- `i_rst_n` in 1 — asynchronous active-low reset
- `i_ex_valid` in 1 — EX holds a valid instruction this cycle
- `i_branch_taken` in 1 — branch unit taken flag
- `i_pc_branch` in XLEN — branch unit target
- `i_redirect_valid` in 1 — trap/CSR redirect request
- `i_redirect_pc` in XLEN — trap/CSR target
- `o_imem_req` out 1 — fetch request
- `o_imem_addr` out XLEN — fetch address
- `i_imem_gnt` in 1 — request accepted
- `i_imem_rvalid` in 1 — response valid; in order, ≥1 cycle after gnt
- `i_imem_rdata` in 32 — response word
- `o_if_valid` out 1 — buffered instruction available
- `o_if_pc` out XLEN — PC of head instruction
- `o_if_instr` out 32 — head instruction
- `i_if_ready` in 1 — IF/ID consumes head
- `o_flush` out 1 — kill IF/ID and ID/EX contents
- `o_exc_misaligned` out 1 — (macro only) misaligned branch target
- `o_exc_addr` out XLEN — (macro only) offending target

## Operation
- FSM states: BOOT, RUN, HALT (HALT exists only under the macro).
- BOOT: entered on reset; no request; moves to RUN on the first clock after reset release.
- RUN: `o_imem_req` = 1 when outstanding < `MAX_OUTSTANDING` and (fifo_count + outstanding) < `FIFO_DEPTH`. `o_imem_addr` = fetch_pc. On req&gnt: fetch_pc += 4, outstanding += 1.
- On rvalid: outstanding −= 1. If discard_cnt > 0, the word is dropped and discard_cnt −= 1; otherwise {resp_pc, rdata} is pushed and resp_pc += 4.
- FIFO output: `o_if_valid` = !empty; head popped on `o_if_valid & i_if_ready`.
- Branch redirect condition: `i_ex_valid & i_branch_taken`. External redirect: `i_redirect_valid`. Either redirect causes the following:
  - `o_flush` = 1 combinationally in the same cycle.
  - The FIFO is cleared and any pop in that cycle is ignored.
  - fetch_pc and resp_pc are loaded with the target.
  - discard_cnt is loaded with the post-cycle outstanding count, including a req&gnt in this cycle and excluding an rvalid in this cycle.
- A request issued in the redirect cycle still uses the old address and is discarded.
- Simultaneous redirects: the external redirect takes priority over the branch redirect.
- discard_cnt and outstanding never exceed `MAX_OUTSTANDING`; no wrap is possible.
- fetch_pc wraps modulo 2^XLEN.

## Timing
- Reset values:
  - `o_imem_req` = 0, `o_imem_addr` = `RESET_PC`
  - `o_if_valid` = 0, `o_if_pc` = 0, `o_if_instr` = 0
  - `o_exc_misaligned` = 0, `o_exc_addr` = 0
  - internal counters = 0
  - `o_flush` = 0 given idle inputs
- First request: first cycle after reset deassertion + 1 (BOOT cycle).
- Response to output: rdata accepted in cycle N appears at `o_if_valid` in N+1.
- Redirect: target address is presented on `o_imem_addr` in cycle N+1 after the redirect in cycle N.
- Reset mid-transaction: all state is dropped immediately. Responses arriving after reset release are an external-protocol violation and are not supported.

## Configuration
- `FETCH_MISALIGN_EXC_EN` defined:
  - A branch target with [1:0] ≠ 0 does not redirect fetch.
  - `o_flush` = 1 in that cycle, and the FIFO is cleared.
  - Registered `o_exc_misaligned` pulses for 1 cycle in N+1, and `o_exc_addr` = target.
  - FSM enters HALT: no requests, in-flight responses discarded, `o_if_valid` = 0.
  - HALT exits only on `i_redirect_valid` (normal redirect to `i_redirect_pc`, state goes to RUN).
- Undefined:
  - Target bits [1:0] are forced to 0.
  - No HALT state; exception ports are absent.

## Structure
- Shared core package: `fetch_state_e` enum {BOOT, RUN, HALT} and the `RESET_PC` default, alongside the existing opcode/branch constants.
- Sub-module `fetch_fifo`:
  - `FIFO_DEPTH`-entry synchronous FIFO of {pc, instr}.
  - Push, pop and synchronous clear; clear has priority over push and pop.
  - Provides a count output.

## Test plan
- Reset release, gnt always 1, rvalid 1 cycle later, `i_if_ready`=1 → addresses 0x0, 0x4, 0x8…; `o_if_pc` 0x0 appears 3 cycles after reset release.
- `i_if_ready`=0 with `FIFO_DEPTH`=2 → exactly 2 requests granted, then `o_imem_req` held 0 until a pop.
- Branch taken to 0x100 while 2 requests are outstanding → `o_flush` same cycle; next 2 rvalids dropped; `o_if_pc`=0x100 is the first valid output.
- Branch to 0x200 and external redirect to 0x80 in the same cycle → next `o_imem_addr`=0x80.
- Macro on, branch to 0x102 → `o_exc_misaligned`=1 for one cycle with `o_exc_addr`=0x102, no requests; `i_redirect_pc`=0x40 resumes fetch at 0x40.
- Macro off, branch to 0x102 → fetch resumes at 0x100.
